// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: FSM states,
// supported opcodes and the datapath mux/ALU select codes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    ST_RST,
    ST_IF,
    ST_ID,
    ST_EXR,
    ST_WBR,
    ST_EXI,
    ST_WBI,
    ST_MA,
    ST_MRD,
    ST_MWR,
    ST_WBM,
    ST_BR,
    ST_JMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b111;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // An instruction retires when the FSM falls back to IF from any state
  // other than IF itself, ID (illegal opcode) or RST.
  function automatic logic isRetire(state_t cur, state_t nxt);
    return (nxt == ST_IF) && (cur != ST_IF) && (cur != ST_ID) && (cur != ST_RST);
  endfunction

endpackage

// File: rtl/ctrl_perf_ctr.sv
// Retired-instruction and cycle counters for the multi-cycle controller.
// Both clear on synchronous reset and wrap naturally at 2^PERF_W.
module ctrl_perf_ctr #(
  parameter int PERF_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              Retire_i,
  output logic [PERF_W-1:0] Retired_o,
  output logic [PERF_W-1:0] Cycles_o
);

  localparam logic [PERF_W-1:0] ONE = PERF_W'(1);

  logic [PERF_W-1:0] r_retired;
  logic [PERF_W-1:0] r_cycles;

  // Count every non-reset cycle, and every retirement reported by the FSM.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_retired <= '0;
      r_cycles  <= '0;
    end else begin
      r_cycles <= r_cycles + ONE;
      if (Retire_i) begin
        r_retired <= r_retired + ONE;
      end
    end
  end

  assign Retired_o = r_retired;
  assign Cycles_o  = r_cycles;

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Moore FSM controller for the multi-cycle MIPS datapath (IF/ID/EX/MEM/WB).
// Optional feature macro: CTRL_PERF_EN adds the Retired_o / Cycles_o
// performance counters (ctrl_perf_ctr); without it those ports do not exist.
module multi_cycle_ctrl
  import ctrl_pkg::*;
`ifdef CTRL_PERF_EN
#(
  parameter int PERF_W = 32
)
`endif
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] Op_i,
  input  logic       Zero_i,
  input  logic       MemReady_i,
  output logic       PCEn_o,
  output logic       IorD_o,
  output logic       MemRead_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic       RegDst_o,
  output logic       MemtoReg_o,
  output logic       RegWrite_o,
  output logic       ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [2:0] ALUOp_o,
  output logic [1:0] PCSource_o,
  output logic       Illegal_o
`ifdef CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] Retired_o,
  output logic [PERF_W-1:0] Cycles_o
`endif
);

  state_t r_state;
  state_t w_next;

  logic       w_pcWrite;
  logic       w_pcWriteCond;
  logic       w_iorD;
  logic       w_memRead;
  logic       w_memWrite;
  logic       w_irWrite;
  logic       w_regDst;
  logic       w_memtoReg;
  logic       w_regWrite;
  logic       w_aluSrcA;
  logic [1:0] w_aluSrcB;
  logic [2:0] w_aluOp;
  logic [1:0] w_pcSource;
  logic       w_illegal;
  logic       w_run;

  // State register; reset parks the FSM in RST, from which it always goes to IF.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_RST;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and control decode; everything defaults to idle/zero.
  always_comb begin
    w_next        = r_state;
    w_pcWrite     = 1'b0;
    w_pcWriteCond = 1'b0;
    w_iorD        = 1'b0;
    w_memRead     = 1'b0;
    w_memWrite    = 1'b0;
    w_irWrite     = 1'b0;
    w_regDst      = 1'b0;
    w_memtoReg    = 1'b0;
    w_regWrite    = 1'b0;
    w_aluSrcA     = 1'b0;
    w_aluSrcB     = SRCB_RT;
    w_aluOp       = ALUOP_ADD;
    w_pcSource    = PCSRC_ALU;
    w_illegal     = 1'b0;

    case (r_state)
      ST_RST: begin
        w_next = ST_IF;
      end
      ST_IF: begin
        w_memRead = 1'b1;
        w_aluSrcB = SRCB_FOUR;
        if (MemReady_i) begin
          w_irWrite = 1'b1;
          w_pcWrite = 1'b1;
          w_next    = ST_ID;
        end
      end
      ST_ID: begin
        w_aluSrcB = SRCB_IMM_SH2;
        case (Op_i)
          OP_RTYPE:     w_next = ST_EXR;
          OP_ADDI:      w_next = ST_EXI;
          OP_LW, OP_SW: w_next = ST_MA;
          OP_BEQ:       w_next = ST_BR;
          OP_J:         w_next = ST_JMP;
          default: begin
            w_illegal = 1'b1;
            w_next    = ST_IF;
          end
        endcase
      end
      ST_EXR: begin
        w_aluSrcA = 1'b1;
        w_aluOp   = ALUOP_RTYPE;
        w_next    = ST_WBR;
      end
      ST_WBR: begin
        w_regDst   = 1'b1;
        w_regWrite = 1'b1;
        w_next     = ST_IF;
      end
      ST_EXI: begin
        w_aluSrcA = 1'b1;
        w_aluSrcB = SRCB_IMM;
        w_next    = ST_WBI;
      end
      ST_WBI: begin
        w_regWrite = 1'b1;
        w_next     = ST_IF;
      end
      ST_MA: begin
        w_aluSrcA = 1'b1;
        w_aluSrcB = SRCB_IMM;
        w_next    = (Op_i == OP_LW) ? ST_MRD : ST_MWR;
      end
      ST_MRD: begin
        w_memRead = 1'b1;
        w_iorD    = 1'b1;
        if (MemReady_i) begin
          w_next = ST_WBM;
        end
      end
      ST_MWR: begin
        w_memWrite = 1'b1;
        w_iorD     = 1'b1;
        if (MemReady_i) begin
          w_next = ST_IF;
        end
      end
      ST_WBM: begin
        w_memtoReg = 1'b1;
        w_regWrite = 1'b1;
        w_next     = ST_IF;
      end
      ST_BR: begin
        w_aluSrcA     = 1'b1;
        w_aluOp       = ALUOP_SUB;
        w_pcSource    = PCSRC_ALUOUT;
        w_pcWriteCond = 1'b1;
        w_next        = ST_IF;
      end
      ST_JMP: begin
        w_pcSource = PCSRC_JUMP;
        w_pcWrite  = 1'b1;
        w_next     = ST_IF;
      end
      default: begin
        w_next = ST_RST;
      end
    endcase
  end

  // Reset forces every control line low immediately, even mid-instruction,
  // so no write enable reaches the datapath while rst_i is high.
  assign w_run = ~rst_i;

  assign PCEn_o     = w_run & (w_pcWrite | (w_pcWriteCond & Zero_i));
  assign IorD_o     = w_run & w_iorD;
  assign MemRead_o  = w_run & w_memRead;
  assign MemWrite_o = w_run & w_memWrite;
  assign IRWrite_o  = w_run & w_irWrite;
  assign RegDst_o   = w_run & w_regDst;
  assign MemtoReg_o = w_run & w_memtoReg;
  assign RegWrite_o = w_run & w_regWrite;
  assign ALUSrcA_o  = w_run & w_aluSrcA;
  assign ALUSrcB_o  = w_aluSrcB & {2{w_run}};
  assign ALUOp_o    = w_aluOp & {3{w_run}};
  assign PCSource_o = w_pcSource & {2{w_run}};
  assign Illegal_o  = w_run & w_illegal;

`ifdef CTRL_PERF_EN
  logic w_retire;

  assign w_retire = w_run & isRetire(r_state, w_next);

  ctrl_perf_ctr #(
    .PERF_W(PERF_W)
  ) uPerf (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .Retire_i (w_retire),
    .Retired_o(Retired_o),
    .Cycles_o (Cycles_o)
  );
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed, table-driven bench for multi_cycle_ctrl, plus latency sequences
// for each instruction class. Counter checks are built when CTRL_PERF_EN is set.
module tb_multi_cycle_ctrl;

  localparam logic [5:0] T_RT   = 6'b000000;
  localparam logic [5:0] T_ADDI = 6'b001000;
  localparam logic [5:0] T_LW   = 6'b100011;
  localparam logic [5:0] T_SW   = 6'b101011;
  localparam logic [5:0] T_BEQ  = 6'b000100;
  localparam logic [5:0] T_J    = 6'b000010;
  localparam logic [5:0] T_ILL  = 6'b111111;

  // Packed order: PCEn IorD MemRead MemWrite IRWrite RegDst MemtoReg RegWrite
  //               ALUSrcA ALUSrcB[1:0] ALUOp[2:0] PCSource[1:0] Illegal
  localparam logic [16:0] E_ZERO  = '0;
  localparam logic [16:0] E_IF0   = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b000,2'b00,1'b0};
  localparam logic [16:0] E_IF1   = {1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,3'b000,2'b00,1'b0};
  localparam logic [16:0] E_ID    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,3'b000,2'b00,1'b0};
  localparam logic [16:0] E_IDILL = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,3'b000,2'b00,1'b1};
  localparam logic [16:0] E_EXR   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b111,2'b00,1'b0};
  localparam logic [16:0] E_WBR   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,3'b000,2'b00,1'b0};
  localparam logic [16:0] E_EXI   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b000,2'b00,1'b0};
  localparam logic [16:0] E_WBI   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,3'b000,2'b00,1'b0};
  localparam logic [16:0] E_MA    = E_EXI;
  localparam logic [16:0] E_MRD   = {1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,2'b00,1'b0};
  localparam logic [16:0] E_MWR   = {1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,2'b00,1'b0};
  localparam logic [16:0] E_WBM   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,3'b000,2'b00,1'b0};
  localparam logic [16:0] E_BRZ   = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b001,2'b01,1'b0};
  localparam logic [16:0] E_BRN   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b001,2'b01,1'b0};
  localparam logic [16:0] E_JMP   = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,2'b10,1'b0};

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        zero;
    logic        ready;
    logic [16:0] exp;
    int          expRetired;
    int          expCycles;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [5:0] Op_i;
  logic       Zero_i;
  logic       MemReady_i;
  logic       PCEn_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o;
  logic       RegDst_o, MemtoReg_o, RegWrite_o, ALUSrcA_o, Illegal_o;
  logic [1:0] ALUSrcB_o;
  logic [2:0] ALUOp_o;
  logic [1:0] PCSource_o;
`ifdef CTRL_PERF_EN
  logic [31:0] Retired_o;
  logic [31:0] Cycles_o;
`endif

  int nCompared;
  int nMismatched;
  vec_t vecs[$];

  multi_cycle_ctrl dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .Op_i      (Op_i),
    .Zero_i    (Zero_i),
    .MemReady_i(MemReady_i),
    .PCEn_o    (PCEn_o),
    .IorD_o    (IorD_o),
    .MemRead_o (MemRead_o),
    .MemWrite_o(MemWrite_o),
    .IRWrite_o (IRWrite_o),
    .RegDst_o  (RegDst_o),
    .MemtoReg_o(MemtoReg_o),
    .RegWrite_o(RegWrite_o),
    .ALUSrcA_o (ALUSrcA_o),
    .ALUSrcB_o (ALUSrcB_o),
    .ALUOp_o   (ALUOp_o),
    .PCSource_o(PCSource_o),
    .Illegal_o (Illegal_o)
`ifdef CTRL_PERF_EN
    ,
    .Retired_o (Retired_o),
    .Cycles_o  (Cycles_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] packOutputs();
    return {PCEn_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o, RegDst_o, MemtoReg_o,
            RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o, PCSource_o, Illegal_o};
  endfunction

  // Drive one cycle of inputs midway between rising edges and let them settle.
  task automatic applyStimulus(input logic r, input logic [5:0] op, input logic z, input logic rdy);
    @(negedge clk);
    rst        = r;
    Op_i       = op;
    Zero_i     = z;
    MemReady_i = rdy;
    #1;
  endtask

  task automatic checkOutput(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, got, exp);
    end
  endtask

  // From an IF cycle, run one instruction with memory always ready and count
  // cycles until IF is seen again; that IF is then held with MemReady_i low.
  task automatic measureLatency(input string name, input logic [5:0] op, input int expCycles);
    int  n;
    bit  done;
    applyStimulus(1'b0, op, 1'b0, 1'b1);
    n    = 1;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (MemRead_o && !IorD_o) begin
        MemReady_i = 1'b0;
        done       = 1'b1;
      end else begin
        n++;
      end
    end
    if (!done) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL %s: no return to IF within 20 cycles", name);
    end else begin
      checkOutput(name, 0, n, expCycles);
    end
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    rst         = 1'b1;
    Op_i        = 6'd0;
    Zero_i      = 1'b0;
    MemReady_i  = 1'b0;

    vecs.push_back('{1'b1, T_RT,   1'b0, 1'b0, E_ZERO,  0, 0});
    vecs.push_back('{1'b1, T_RT,   1'b0, 1'b0, E_ZERO,  0, 0});
    vecs.push_back('{1'b1, T_RT,   1'b0, 1'b0, E_ZERO,  0, 0});
    vecs.push_back('{1'b0, T_RT,   1'b0, 1'b0, E_ZERO,  0, 0});
    vecs.push_back('{1'b0, T_RT,   1'b0, 1'b1, E_IF1,   0, 1});
    vecs.push_back('{1'b0, T_RT,   1'b0, 1'b1, E_ID,    0, 2});
    vecs.push_back('{1'b0, T_RT,   1'b0, 1'b1, E_EXR,   0, 3});
    vecs.push_back('{1'b0, T_RT,   1'b0, 1'b1, E_WBR,   0, 4});
    vecs.push_back('{1'b0, T_LW,   1'b1, 1'b0, E_IF0,   1, 5});
    vecs.push_back('{1'b0, T_LW,   1'b0, 1'b1, E_IF1,   1, 6});
    vecs.push_back('{1'b0, T_LW,   1'b0, 1'b1, E_ID,    1, 7});
    vecs.push_back('{1'b0, T_LW,   1'b0, 1'b1, E_MA,    1, 8});
    vecs.push_back('{1'b0, T_LW,   1'b0, 1'b0, E_MRD,   1, 9});
    vecs.push_back('{1'b0, T_LW,   1'b0, 1'b0, E_MRD,   1, 10});
    vecs.push_back('{1'b0, T_LW,   1'b0, 1'b1, E_MRD,   1, 11});
    vecs.push_back('{1'b0, T_LW,   1'b0, 1'b1, E_WBM,   1, 12});
    vecs.push_back('{1'b0, T_BEQ,  1'b0, 1'b1, E_IF1,   2, 13});
    vecs.push_back('{1'b0, T_BEQ,  1'b1, 1'b1, E_ID,    2, 14});
    vecs.push_back('{1'b0, T_BEQ,  1'b1, 1'b1, E_BRZ,   2, 15});
    vecs.push_back('{1'b0, T_BEQ,  1'b0, 1'b1, E_IF1,   3, 16});
    vecs.push_back('{1'b0, T_BEQ,  1'b0, 1'b1, E_ID,    3, 17});
    vecs.push_back('{1'b0, T_BEQ,  1'b0, 1'b1, E_BRN,   3, 18});
    vecs.push_back('{1'b0, T_ILL,  1'b0, 1'b1, E_IF1,   4, 19});
    vecs.push_back('{1'b0, T_ILL,  1'b0, 1'b1, E_IDILL, 4, 20});
    vecs.push_back('{1'b0, T_ADDI, 1'b0, 1'b1, E_IF1,   4, 21});
    vecs.push_back('{1'b0, T_ADDI, 1'b0, 1'b1, E_ID,    4, 22});
    vecs.push_back('{1'b0, T_ADDI, 1'b0, 1'b1, E_EXI,   4, 23});
    vecs.push_back('{1'b0, T_ADDI, 1'b0, 1'b1, E_WBI,   4, 24});
    vecs.push_back('{1'b0, T_J,    1'b0, 1'b1, E_IF1,   5, 25});
    vecs.push_back('{1'b0, T_J,    1'b0, 1'b1, E_ID,    5, 26});
    vecs.push_back('{1'b0, T_J,    1'b0, 1'b1, E_JMP,   5, 27});
    vecs.push_back('{1'b0, T_SW,   1'b0, 1'b1, E_IF1,   6, 28});
    vecs.push_back('{1'b0, T_SW,   1'b0, 1'b1, E_ID,    6, 29});
    vecs.push_back('{1'b0, T_SW,   1'b0, 1'b1, E_MA,    6, 30});
    vecs.push_back('{1'b0, T_SW,   1'b0, 1'b0, E_MWR,   6, 31});
    vecs.push_back('{1'b1, T_SW,   1'b0, 1'b0, E_ZERO,  6, 32});
    vecs.push_back('{1'b0, T_SW,   1'b0, 1'b0, E_ZERO,  0, 0});
    vecs.push_back('{1'b0, T_SW,   1'b0, 1'b0, E_IF0,   0, 1});

    $display("[TB] applying %0d directed vectors", vecs.size());
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].op, vecs[i].zero, vecs[i].ready);
      checkOutput("outputs", i, 32'(packOutputs()), 32'(vecs[i].exp));
      checkOutput("illegal_and_regwrite", i, 32'(Illegal_o & RegWrite_o), 32'd0);
`ifdef CTRL_PERF_EN
      checkOutput("retired", i, Retired_o, vecs[i].expRetired);
      checkOutput("cycles", i, Cycles_o, vecs[i].expCycles);
`endif
    end

    $display("[TB] measuring per-class latency with memory always ready");
    measureLatency("lat_rtype", T_RT,   4);
    measureLatency("lat_addi",  T_ADDI, 4);
    measureLatency("lat_beq",   T_BEQ,  3);
    measureLatency("lat_j",     T_J,    3);
    measureLatency("lat_sw",    T_SW,   4);
    measureLatency("lat_lw",    T_LW,   5);
`ifdef CTRL_PERF_EN
    checkOutput("retired_after_latency", 0, Retired_o, 32'd6);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
